// File: rtl/fp_mul_round_pack.sv
// -----------------------------------------------------------------------------
// fp_mul_round_pack
// Post-multiply stage of the single-precision FP multiplier. Takes the raw
// exponent sum and the 48-bit significand product from the multiply core. It
// normalizes the product, rounds to nearest-even, resolves special operands and
// exponent range, and packs an IEEE-754 binary32 result. Two pipeline stages
// (S1 normalize, S2 round/pack) sit behind a valid/ready handshake.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready drops only while the output stalls
//   in_sign         product sign (A_sign ^ B_sign)
//   in_exp_sum      A_exp + B_exp, bias not yet removed
//   in_product      {1,A_man} * {1,B_man}
//   in_a/b_class    00 normal, 01 zero/subnormal, 10 inf, 11 NaN
//   out_valid/ready output handshake
//   result          packed binary32 {sign, exp, man}
//   flag_*          overflow, underflow, invalid, inexact (zero when !out_valid)
// -----------------------------------------------------------------------------
module fp_mul_round_pack #(
    parameter int WIDTH = 32,
    parameter int BIAS  = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [8:0]        in_exp_sum,
    input  logic [47:0]       in_product,
    input  logic [1:0]        in_a_class,
    input  logic [1:0]        in_b_class,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_ovf,
    output logic              flag_unf,
    output logic              flag_inv,
    output logic              flag_inx
);

    typedef enum logic [1:0] {
        CLASS_NORMAL = 2'b00,
        CLASS_ZERO   = 2'b01,
        CLASS_INF    = 2'b10,
        CLASS_NAN    = 2'b11
    } OpClass;

    localparam logic [WIDTH-1:0] QUIET_NAN = 32'h7FC0_0000;

    // Both stages move together; the only thing that can hold them is a result
    // sitting on the output that the consumer has not taken yet.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage 1 registers
    logic        s1Valid;
    logic        s1Sign;
    OpClass      s1AClass;
    OpClass      s1BClass;
    logic [22:0] s1Man;
    logic        s1Guard;
    logic        s1Sticky;
    logic [10:0] s1Exp;

    // Normalization: the product of two [1,2) significands lies in [1,4), so
    // bit 47 tells us whether the leading one is at 47 or 46. The exponent is
    // kept as 11-bit two's complement so that both underflow (negative) and
    // overflow (>= 255) survive until the range checks in S2.
    logic        prodTop;
    logic [22:0] normMan;
    logic        normGuard;
    logic        normSticky;
    logic [10:0] normExp;

    always_comb begin
        prodTop    = in_product[47];
        normMan    = prodTop ? in_product[46:24] : in_product[45:23];
        normGuard  = prodTop ? in_product[23]    : in_product[22];
        normSticky = prodTop ? (|in_product[22:0]) : (|in_product[21:0]);
        normExp    = {2'b00, in_exp_sum} - 11'(BIAS) + {10'b0, prodTop};
    end

    // S1 captures the normalized fields whenever the pipe is not stalled;
    // a bubble on the input simply clears the stage valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid  <= 1'b0;
            s1Sign   <= 1'b0;
            s1AClass <= CLASS_NORMAL;
            s1BClass <= CLASS_NORMAL;
            s1Man    <= '0;
            s1Guard  <= 1'b0;
            s1Sticky <= 1'b0;
            s1Exp    <= '0;
        end else if (!stall) begin
            s1Valid  <= in_valid;
            s1Sign   <= in_sign;
            s1AClass <= OpClass'(in_a_class);
            s1BClass <= OpClass'(in_b_class);
            s1Man    <= normMan;
            s1Guard  <= normGuard;
            s1Sticky <= normSticky;
            s1Exp    <= normExp;
        end
    end

    // Round to nearest-even, then resolve specials and range. A carry out of
    // the mantissa leaves the fraction at zero and bumps the exponent, which
    // is why rounding happens before the overflow check.
    logic             roundUp;
    logic [23:0]      manSum;
    logic [10:0]      roundExp;
    logic [WIDTH-1:0] nextResult;
    logic             nextOvf;
    logic             nextUnf;
    logic             nextInv;
    logic             nextInx;
    logic             anyNan;
    logic             anyInf;
    logic             anyZero;
    logic             infTimesZero;

    always_comb begin
        roundUp  = s1Guard & (s1Sticky | s1Man[0]);
        manSum   = {1'b0, s1Man} + {23'b0, roundUp};
        roundExp = s1Exp + {10'b0, manSum[23]};

        anyNan       = (s1AClass == CLASS_NAN)  | (s1BClass == CLASS_NAN);
        anyInf       = (s1AClass == CLASS_INF)  | (s1BClass == CLASS_INF);
        anyZero      = (s1AClass == CLASS_ZERO) | (s1BClass == CLASS_ZERO);
        infTimesZero = anyInf & anyZero;

        nextResult = {s1Sign, roundExp[7:0], manSum[22:0]};
        nextOvf    = 1'b0;
        nextUnf    = 1'b0;
        nextInv    = 1'b0;
        nextInx    = s1Guard | s1Sticky;

        if (anyNan) begin
            nextResult = QUIET_NAN;
            nextInx    = 1'b0;
        end else if (infTimesZero) begin
            nextResult = QUIET_NAN;
            nextInv    = 1'b1;
            nextInx    = 1'b0;
        end else if (anyInf) begin
            nextResult = {s1Sign, 8'hFF, 23'b0};
            nextInx    = 1'b0;
        end else if (anyZero) begin
            nextResult = {s1Sign, 31'b0};
            nextInx    = 1'b0;
        end else if ($signed(roundExp) >= 11'sd255) begin
            nextResult = {s1Sign, 8'hFF, 23'b0};
            nextOvf    = 1'b1;
            nextInx    = 1'b1;
        end else if ($signed(roundExp) <= 11'sd0) begin
            nextResult = {s1Sign, 31'b0};
            nextUnf    = 1'b1;
            nextInx    = 1'b1;
        end
    end

    // S2 is the registered output. Bubbles clear result and flags so that
    // nothing but a valid beat ever shows nonzero flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_inv  <= 1'b0;
            flag_inx  <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                result   <= nextResult;
                flag_ovf <= nextOvf;
                flag_unf <= nextUnf;
                flag_inv <= nextInv;
                flag_inx <= nextInx;
            end else begin
                result   <= '0;
                flag_ovf <= 1'b0;
                flag_unf <= 1'b0;
                flag_inv <= 1'b0;
                flag_inx <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_round_pack
// Scoreboard bench for fp_mul_round_pack. Stimulus pushes the expected packed
// result and flags (from an arithmetic reference model) into a queue when a
// beat is accepted; a monitor on the falling edge compares whatever the DUT
// presents against the head of that queue and pops on a consumer handshake.
// -----------------------------------------------------------------------------
module tb_fp_mul_round_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp_sum;
    logic [47:0] in_product;
    logic [1:0]  in_a_class;
    logic [1:0]  in_b_class;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inv;
    logic        flag_inx;

    int checks = 0;
    int errors = 0;

    // Expected {result, ovf, unf, inv, inx}
    logic [35:0] expQ[$];

    fp_mul_round_pack #(.WIDTH(32), .BIAS(127)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp_sum (in_exp_sum),
        .in_product (in_product),
        .in_a_class (in_a_class),
        .in_b_class (in_b_class),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_ovf   (flag_ovf),
        .flag_unf   (flag_unf),
        .flag_inv   (flag_inv),
        .flag_inx   (flag_inx)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: works on the whole product as an integer, rounding by
    // comparing the discarded remainder against one half ulp.
    function automatic logic [35:0] refModel(input logic sign, input logic [8:0] expSum,
                                             input logic [47:0] product,
                                             input logic [1:0] aC, input logic [1:0] bC);
        longint unsigned prodVal;
        longint unsigned mant;
        longint unsigned rem;
        longint unsigned half;
        int              shift;
        int              e;
        logic            inexact;
        logic [7:0]      eBits;
        logic [22:0]     manBits;
        if (aC == 2'd3 || bC == 2'd3) return {32'h7FC0_0000, 4'b0000};
        if ((aC == 2'd2 && bC == 2'd1) || (aC == 2'd1 && bC == 2'd2))
            return {32'h7FC0_0000, 4'b0010};
        if (aC == 2'd2 || bC == 2'd2) return {sign, 8'hFF, 23'h0, 4'b0000};
        if (aC == 2'd1 || bC == 2'd1) return {sign, 31'h0, 4'b0000};
        prodVal = {16'h0, product};
        shift   = (prodVal >= 64'h8000_0000_0000) ? 24 : 23;
        mant    = prodVal >> shift;
        rem     = prodVal % (64'd1 << shift);
        half    = 64'd1 << (shift - 1);
        e       = int'(expSum) - 127 + ((shift == 24) ? 1 : 0);
        inexact = (rem != 0);
        if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {sign, 8'hFF, 23'h0, 4'b1001};
        if (e <= 0)   return {sign, 31'h0, 4'b0101};
        eBits   = e[7:0];
        manBits = mant[22:0];
        return {sign, eBits, manBits, 3'b000, inexact};
    endfunction

    // Every comparison goes through here so the counters stay in one place
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge, decide at the
    // falling edge whether the beat will transfer, and record its expectation.
    task automatic applyStimulus(input logic valid, input logic sign, input logic [8:0] expSum,
                                 input logic [47:0] product, input logic [1:0] aC,
                                 input logic [1:0] bC, input logic rdy);
        @(posedge clk);
        #1;
        in_valid   = valid;
        in_sign    = sign;
        in_exp_sum = expSum;
        in_product = product;
        in_a_class = aC;
        in_b_class = bC;
        out_ready  = rdy;
        @(negedge clk);
        if (in_valid && in_ready) expQ.push_back(refModel(sign, expSum, product, aC, bC));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 9'd0, 48'h0, 2'd0, 2'd0, 1'b1);
    endtask

    // Monitor: compare the presented output against the queue head every
    // cycle it is valid, so a stalled output is also checked for stability.
    always @(negedge clk) begin
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected output: got %0h, expected no output", result);
            end else begin
                checkOutput("result", {32'h0, result}, {32'h0, expQ[0][35:4]});
                checkOutput("flags", {60'h0, flag_ovf, flag_unf, flag_inv, flag_inx},
                            {60'h0, expQ[0][3:0]});
                if (out_ready) void'(expQ.pop_front());
            end
        end else begin
            checkOutput("idle flags", {60'h0, flag_ovf, flag_unf, flag_inv, flag_inx}, 64'h0);
        end
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] ma;
        logic [23:0] mb;
        logic [8:0]  es;
        logic [1:0]  ac;
        logic [1:0]  bc;
        int          sent;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp_sum = '0;
        in_product = '0;
        in_a_class = '0;
        in_b_class = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset out_valid", {63'h0, out_valid}, 64'h0);
        checkOutput("reset result", {32'h0, result}, 64'h0);
        checkOutput("reset in_ready", {63'h0, in_ready}, 64'h1);

        // 1.5 * 1.5 with exact two-cycle latency
        applyStimulus(1'b1, 1'b0, 9'd254, 48'h9000_0000_0000, 2'd0, 2'd0, 1'b1);
        idleCycle();
        checkOutput("latency cycle 1", {63'h0, out_valid}, 64'h0);
        idleCycle();
        checkOutput("latency cycle 2", {63'h0, out_valid}, 64'h1);
        checkOutput("1.5x1.5", {32'h0, result}, 64'h4010_0000);

        // Ties-to-even, range limits, specials and carry-out rounding
        applyStimulus(1'b1, 1'b0, 9'd254, 48'h8000_0180_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd254, 48'h8000_0080_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd400, 48'h8000_0000_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd100, 48'h8000_0000_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd254, 48'h8000_0000_0000, 2'd2, 2'd1, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'd254, 48'h8000_0000_0000, 2'd1, 2'd2, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd254, 48'h8000_0000_0000, 2'd3, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'd254, 48'h8000_0000_0000, 2'd2, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'd254, 48'h8000_0000_0000, 2'd0, 2'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd200, 48'h7FFF_FFC0_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd381, 48'h7FFF_FFC0_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd127, 48'h4000_0000_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd128, 48'h4000_0000_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'd381, 48'h4000_0000_0000, 2'd0, 2'd0, 1'b1);
        repeat (3) idleCycle();

        // Backpressure: consumer stalls for three cycles while four beats stream
        sent = 0;
        for (int c = 0; c < 30 && sent < 4; c++) begin
            applyStimulus(1'b1, sent[0], 9'd130 + 9'(sent),
                          48'h9000_0000_0000 + 48'(sent) * 48'h0000_0123_4567,
                          2'd0, 2'd0, (c < 2 || c > 4));
            if (c >= 2 && c <= 4) checkOutput("in_ready while stalled", {63'h0, in_ready}, 64'h0);
            if (in_ready) sent++;
        end
        checkOutput("backpressure beats sent", 64'(sent), 64'd4);
        repeat (4) idleCycle();
        checkOutput("backpressure drained", 64'(expQ.size()), 64'h0);

        // Reset with two beats in flight, then one clean beat afterwards
        applyStimulus(1'b1, 1'b0, 9'd140, 48'h9000_0000_0000, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 9'd141, 48'hA000_0000_0000, 2'd0, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        in_valid   = 1'b1;
        in_sign    = 1'b0;
        in_exp_sum = 9'd254;
        in_product = 48'h9000_0000_0000;
        in_a_class = 2'd0;
        in_b_class = 2'd0;
        @(negedge clk);
        checkOutput("post-reset out_valid", {63'h0, out_valid}, 64'h0);
        checkOutput("post-reset result", {32'h0, result}, 64'h0);
        if (in_ready) expQ.push_back(refModel(1'b0, 9'd254, 48'h9000_0000_0000, 2'd0, 2'd0));
        idleCycle();
        checkOutput("post-reset latency 1", {63'h0, out_valid}, 64'h0);
        idleCycle();
        checkOutput("post-reset latency 2", {63'h0, out_valid}, 64'h1);
        repeat (2) idleCycle();

        // Randomized traffic with random bubbles and backpressure
        for (int c = 0; c < 400; c++) begin
            ma = {1'b1, 23'($urandom)};
            mb = {1'b1, 23'($urandom)};
            case ($urandom_range(0, 3))
                0:       es = 9'($urandom_range(120, 135));
                1:       es = 9'($urandom_range(375, 386));
                default: es = 9'($urandom_range(0, 510));
            endcase
            ac = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), es,
                          48'(ma) * 48'(mb), ac, bc, $urandom_range(0, 3) != 0);
        end

        for (int c = 0; c < 20 && expQ.size() != 0; c++) idleCycle();
        checkOutput("final drain", 64'(expQ.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
